// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int XLEN = 32;

    // Byte distance between consecutive instruction words.
    localparam logic [XLEN-1:0] INST_INC = 32'd4;

    // Fetch controller states.
    //   ST_IDLE  : no request outstanding
    //   ST_WAIT  : request outstanding, its response will be kept
    //   ST_FLUSH : request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary (low two bits cleared).
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Address of the next sequential instruction; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
        return addr + INST_INC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode. Power-of-two depth,
// simultaneous push and pop supported, flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == DEPTH_C);
    assign w_do_pop  = i_pop && (r_count != '0);
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Buffer storage, pointers and occupancy; flush discards everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Head is presented as zero while empty so stale entries never leak out.
    always_comb begin
        o_head = '0;
        if (r_count != '0) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time to instruction
// memory, buffers responses for decode, and handles control-flow redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;

    fetch_state_e    w_state_next;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_addr_next;
    logic            w_push;
    logic            w_pop;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic            w_has_room;
    logic            w_fifo_valid;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    // A redirect kills both the incoming response and any pop in the same cycle.
    assign w_push       = (r_state == ST_WAIT) && imem_ack && !redirect;
    assign w_pop        = w_fifo_valid && inst_ready && !redirect;
    assign w_push_data  = '{pc: r_imem_addr, inst: imem_rdata};
    // Occupancy after this cycle's push/pop; a new request needs a free slot in it.
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_has_room   = (w_count_next < DEPTH_C);

    // Next-state, next-pc and next-request-address decision.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_imem_addr;
        case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_pc_next = word_align(redirect_pc);
                end else if (w_has_room) begin
                    w_state_next = ST_WAIT;
                    w_addr_next  = r_pc;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_pc_next = word_align(redirect_pc);
                    if (imem_ack) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_FLUSH;
                    end
                end else if (imem_ack) begin
                    w_pc_next = next_pc(r_pc);
                    if (w_has_room) begin
                        w_state_next = ST_WAIT;
                        w_addr_next  = next_pc(r_pc);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    w_pc_next = word_align(redirect_pc);
                end else begin
                    w_pc_next = r_pc;
                end
                // The stale response ends the outstanding request either way.
                if (imem_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered memory-request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_imem_req  <= (w_state_next != ST_IDLE);
            r_imem_addr <= w_addr_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_count)
    );

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = w_fifo_valid;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign opcode     = w_head.inst[6:0];
    assign funct3     = w_head.inst[14:12];
    assign funct7     = w_head.inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table on a default instance plus
// hand-written sequences for address wrap and back-pressure on a second
// instance (RESET_PC near the top of memory, four-entry buffer).
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ack, rdy, redir;
    logic [31:0] rpc;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, rdata_a, inst_a, ipc_a, addr_b, rdata_b, inst_b, ipc_b;
    logic [6:0]  opc_a, f7_a, opc_b, f7_b;
    logic [2:0]  f3_a, f3_b;

    int n_chk = 0;
    int n_err = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5B3;
    endfunction

    assign rdata_a = mem(addr_a);
    assign rdata_b = mem(addr_b);

    fetch_unit dut_a (
        .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(ack), .imem_rdata(rdata_a), .inst_valid(valid_a),
        .inst_ready(rdy), .inst(inst_a), .inst_pc(ipc_a), .opcode(opc_a),
        .funct3(f3_a), .funct7(f7_a), .redirect(redir), .redirect_pc(rpc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack), .imem_rdata(rdata_b), .inst_valid(valid_b),
        .inst_ready(rdy), .inst(inst_b), .inst_pc(ipc_b), .opcode(opc_b),
        .funct3(f3_b), .funct7(f7_b), .redirect(redir), .redirect_pc(rpc)
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    initial begin
        int acc_a, acc_b;
        logic [31:0] exp_pc, exp_inst;

        // rst ack rdy redir rpc | req addr valid pc  (outputs seen during that cycle)
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0});   // reset beats redirect/ack
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0});   // first request
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC});   // ack delayed at 0x10
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 1'b1, 32'h14,  1'b1, 32'h10});  // redirect while outstanding
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0});   // flush: request held
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0});   // stale ack dropped
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h208, 1'b1, 32'h204}); // redirect + ack + pop
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h300});

        reset = 1'b1; ack = 1'b0; rdy = 1'b0; redir = 1'b0; rpc = 32'h0;
        tick();
        tick();

        // Cycle table on the default instance.
        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; ack = vq[i].ack; rdy = vq[i].rdy;
            redir = vq[i].redir; rpc = vq[i].rpc;
            @(negedge clk);
            chk("req",   i, {31'd0, req_a},   {31'd0, vq[i].e_req});
            chk("addr",  i, addr_a,           vq[i].e_addr);
            chk("valid", i, {31'd0, valid_a}, {31'd0, vq[i].e_valid});
            if (vq[i].e_valid) begin
                exp_inst = mem(vq[i].e_pc);
                chk("inst_pc", i, ipc_a,  vq[i].e_pc);
                chk("inst",    i, inst_a, exp_inst);
                chk("opcode",  i, {25'd0, opc_a}, {25'd0, exp_inst[6:0]});
                chk("funct3",  i, {29'd0, f3_a},  {29'd0, exp_inst[14:12]});
                chk("funct7",  i, {25'd0, f7_a},  {25'd0, exp_inst[31:25]});
            end
            if (vq[i].rst) begin
                chk("rst_inst",    i, inst_a, 32'h0);
                chk("rst_inst_pc", i, ipc_a,  32'h0);
            end
            tick();
        end

        // Address wrap on the second instance with zero-wait memory.
        reset = 1'b1; ack = 1'b1; rdy = 1'b1; redir = 1'b0; rpc = 32'h0;
        tick();
        tick();
        chk("wrap_rst_addr", 0, addr_b, 32'hFFFF_FFF8);
        reset = 1'b0;
        @(negedge clk);
        chk("wrap_req_idle", 0, {31'd0, req_b}, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            chk("wrap_req",  k, {31'd0, req_b}, 32'd1);
            chk("wrap_addr", k, addr_b, exp_pc);
            if (k > 0) begin
                chk("wrap_valid",   k, {31'd0, valid_b}, 32'd1);
                chk("wrap_inst_pc", k, ipc_b, exp_pc - 32'd4);
            end
            tick();
        end

        // Back-pressure: ready low, ack high; both buffers fill and stop.
        reset = 1'b1; ack = 1'b1; rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        acc_a = 0;
        acc_b = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_a && ack) acc_a++;
            if (req_b && ack) acc_b++;
            tick();
        end
        chk("bp_accepted_a", 0, 32'(acc_a), 32'd2);
        chk("bp_accepted_b", 0, 32'(acc_b), 32'd4);
        chk("bp_req_a",      0, {31'd0, req_a}, 32'd0);
        chk("bp_req_b",      0, {31'd0, req_b}, 32'd0);
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_pc = 32'(4 * k);
            chk("bp_valid_a",   k, {31'd0, valid_a}, 32'd1);
            chk("bp_inst_pc_a", k, ipc_a, exp_pc);
            chk("bp_inst_a",    k, inst_a, mem(exp_pc));
            chk("bp_inst_pc_b", k, ipc_b, 32'hFFFF_FFF8 + exp_pc);
            chk("bp_inst_b",    k, inst_b, mem(32'hFFFF_FFF8 + exp_pc));
            if (k == 0) begin
                chk("bp_req_first_pop_a", k, {31'd0, req_a}, 32'd0);
                chk("bp_req_first_pop_b", k, {31'd0, req_b}, 32'd0);
            end
            if (k == 1) begin
                chk("bp_req_after_pop_a",  k, {31'd0, req_a}, 32'd1);
                chk("bp_addr_after_pop_a", k, addr_a, 32'h8);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
